// File: rtl/matrix_pkg.sv
// Shared definitions for the MATRIX datapath blocks.
//   state_t : sequencing states for the vector multiply engine
//   clog2   : ceiling log2, used to size counters and accumulators
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Smallest r with 2**r >= n (0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/multiply_unitary_s.sv
// Single-lane combinational multiplier, unsigned or two's complement.
//   a, b : NBITS operands
//   sgn  : 1 = operands are two's complement, 0 = unsigned
//   p    : full 2*NBITS product (signed result when sgn=1)
module multiply_unitary_s #(
  parameter int NBITS = 4
) (
  input  logic [NBITS-1:0]   a,
  input  logic [NBITS-1:0]   b,
  input  logic               sgn,
  output logic [2*NBITS-1:0] p
);

  logic signed [2*NBITS-1:0] p_signed;
  logic        [2*NBITS-1:0] p_unsigned;

  // Both operands signed, so they are sign-extended to the product width.
  assign p_signed   = $signed(a) * $signed(b);
  assign p_unsigned = {{NBITS{1'b0}}, a} * {{NBITS{1'b0}}, b};
  assign p          = sgn ? p_signed : p_unsigned;

endmodule

// File: rtl/vector_mult_seq.sv
// Sequential vector multiply engine.
// Streams LANES element pairs per beat through parallel lane multipliers and
// builds both the element-wise product vector and the dot product.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   start        : job request; accepted in IDLE or DONE
//   sgn          : 1 = two's complement operands, 0 = unsigned
//   A, B         : packed operand vectors, element i at [i*NBITS +: NBITS]
//   busy         : high while a job is running
//   done         : one-cycle pulse, results valid (and held until next start)
//   prod_out     : element i = A[i]*B[i] at [i*2*NBITS +: 2*NBITS]
//   dot_out      : sum of all element products
module vector_mult_seq
  import matrix_pkg::*;
#(
  parameter  int NBITS = 4,
  parameter  int NDATA = 8,
  parameter  int LANES = 1,
  localparam int SUMW  = 2*NBITS + clog2(NDATA)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     sgn,
  input  logic [NDATA*NBITS-1:0]   A,
  input  logic [NDATA*NBITS-1:0]   B,
  output logic                     busy,
  output logic                     done,
  output logic [NDATA*2*NBITS-1:0] prod_out,
  output logic [SUMW-1:0]          dot_out
);

  localparam int NBEATS = NDATA / LANES;
  localparam int CW     = (NBEATS > 1) ? clog2(NBEATS) : 1;
  localparam int OPW    = NDATA * NBITS;
  localparam int PRODW  = 2 * NBITS;
  localparam int PW     = NDATA * PRODW;
  localparam int LW     = LANES * PRODW;

  state_t             state;
  logic [CW-1:0]      beat;
  logic [OPW-1:0]     a_sr;
  logic [OPW-1:0]     b_sr;
  logic               sgn_r;
  logic [LW-1:0]      lane_prod;
  logic [SUMW-1:0]    lane_sum;

  // Lanes always consume the low LANES elements of the operand shift regs.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    multiply_unitary_s #(.NBITS(NBITS)) u_mul (
      .a   (a_sr[l*NBITS +: NBITS]),
      .b   (b_sr[l*NBITS +: NBITS]),
      .sgn (sgn_r),
      .p   (lane_prod[l*PRODW +: PRODW])
    );
  end

  // Extend each lane product to accumulator width according to the captured sign mode.
  always_comb begin
    // NOTE: default assignment first so every path drives lane_sum and no latch is inferred.
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (sgn_r)
        lane_sum = lane_sum + SUMW'($signed(lane_prod[l*PRODW +: PRODW]));
      else
        lane_sum = lane_sum + SUMW'(lane_prod[l*PRODW +: PRODW]);
    end
  end

  // NOTE: operand/product registers are plain flops here, so they are reset along with the FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      beat     <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      sgn_r    <= 1'b0;
      prod_out <= '0;
      dot_out  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            beat     <= '0;
            a_sr     <= A;
            b_sr     <= B;
            sgn_r    <= sgn;
            prod_out <= '0;
            dot_out  <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          // Newest lane products enter at the MSB end; after NBEATS beats
          // element 0 has reached the bottom.
          prod_out <= (prod_out >> LW) | (PW'(lane_prod) << (PW - LW));
          dot_out  <= dot_out + lane_sum;
          a_sr     <= a_sr >> (LANES * NBITS);
          b_sr     <= b_sr >> (LANES * NBITS);
          beat     <= beat + 1'b1;
          if (beat == CW'(NBEATS - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mult_seq.sv
// Self-checking bench for vector_mult_seq: one instance with LANES=1 and one
// with LANES=2 share operands and reset; each has its own start.
module tb_vector_mult_seq;

  localparam int NBITS = 4;
  localparam int NDATA = 8;
  localparam int SUMW  = 11;

  logic        clk;
  logic        reset_n;
  logic        start1, start2;
  logic        sgn;
  logic [31:0] A, B;
  logic        busy1, done1, busy2, done2;
  logic [63:0] prod1, prod2;
  logic [10:0] dot1, dot2;

  int n_checks = 0;
  int n_errors = 0;

  vector_mult_seq #(.NBITS(NBITS), .NDATA(NDATA), .LANES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .sgn(sgn), .A(A), .B(B),
    .busy(busy1), .done(done1), .prod_out(prod1), .dot_out(dot1)
  );

  vector_mult_seq #(.NBITS(NBITS), .NDATA(NDATA), .LANES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .sgn(sgn), .A(A), .B(B),
    .busy(busy2), .done(done2), .prod_out(prod2), .dot_out(dot2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic per element.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [63:0] p, output logic [10:0] d);
    int acc, ai, bi, pi;
    logic [3:0] ea, eb;
    acc = 0;
    p   = '0;
    for (int i = 0; i < NDATA; i++) begin
      ea = a[i*4 +: 4];
      eb = b[i*4 +: 4];
      ai = s ? int'($signed(ea)) : int'(ea);
      bi = s ? int'($signed(eb)) : int'(eb);
      pi = ai * bi;
      p[i*8 +: 8] = pi[7:0];
      acc += pi;
    end
    d = acc[10:0];
  endfunction

  function automatic logic done_of(input bit w);
    return w ? done2 : done1;
  endfunction
  function automatic logic busy_of(input bit w);
    return w ? busy2 : busy1;
  endfunction
  function automatic logic [63:0] prod_of(input bit w);
    return w ? prod2 : prod1;
  endfunction
  function automatic logic [10:0] dot_of(input bit w);
    return w ? dot2 : dot1;
  endfunction

  task automatic set_start(input bit w, input logic v);
    if (w) start2 = v;
    else   start1 = v;
  endtask

  // Waits (bounded) for done; returns edges counted since the caller's reference point.
  task automatic wait_done(input bit w, output int cyc);
    cyc = 0;
    while (!done_of(w) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_job(input bit w, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input string tag);
    logic [63:0] ep;
    logic [10:0] ed;
    int cyc;
    model(a, b, s, ep, ed);
    @(negedge clk);
    A = a; B = b; sgn = s;
    set_start(w, 1'b1);
    @(negedge clk);
    set_start(w, 1'b0);
    // Operands are captured; scrambling them must not matter.
    A = $urandom; B = $urandom; sgn = 1'($urandom_range(0, 1));
    check({tag, "_busy"}, 64'(busy_of(w)), 64'd1);
    wait_done(w, cyc);
    check({tag, "_lat"}, 64'(cyc), w ? 64'd4 : 64'd8);
    check({tag, "_prod"}, prod_of(w), ep);
    check({tag, "_dot"}, 64'(dot_of(w)), 64'(ed));
    @(negedge clk);
    check({tag, "_pulse"}, 64'({busy_of(w), done_of(w)}), 64'd0);
  endtask

  localparam logic [31:0] T1_A = 32'h7654_3210;
  localparam logic [31:0] T1_B = 32'h0123_4567;
  localparam logic [63:0] T1_P = 64'h0006_0A0C_0C0A_0600;

  initial begin
    logic [63:0] ep, hold_p;
    logic [10:0] ed, hold_d;
    int cyc;
    reset_n = 1'b0; start1 = 1'b0; start2 = 1'b0; sgn = 1'b0; A = '0; B = '0;
    #12;
    check("rst_ctl1", 64'({busy1, done1}), 64'd0);
    check("rst_out1", prod1 | 64'(dot1), 64'd0);
    check("rst_ctl2", 64'({busy2, done2}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed unsigned case on both lane counts.
    run_job(1'b0, T1_A, T1_B, 1'b0, "t1");
    check("t1_dot_const", 64'(dot1), 64'd56);
    check("t1_prod_const", prod1, T1_P);
    run_job(1'b1, T1_A, T1_B, 1'b0, "t3");
    check("t3_prod_const", prod2, T1_P);
    check("t3_dot_const", 64'(dot2), 64'd56);

    // Signed vs unsigned interpretation of the same bits.
    run_job(1'b0, 32'hFFFF_FFFF, T1_A, 1'b1, "t2s");
    check("t2s_dot_const", 64'(dot1), 64'h7E4);
    check("t2s_e7", 64'(prod1[63:56]), 64'hF9);
    run_job(1'b0, 32'hFFFF_FFFF, T1_A, 1'b0, "t2u");
    check("t2u_dot_const", 64'(dot1), 64'h1A4);

    // Hold: outputs stay put while operands wander with no start.
    hold_p = prod1; hold_d = dot1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      A = $urandom; B = $urandom; sgn = 1'($urandom_range(0, 1));
    end
    check("hold_prod", prod1, T1_P ^ T1_P ^ hold_p);
    model(32'hFFFF_FFFF, T1_A, 1'b0, ep, ed);
    check("hold_prod_model", prod1, ep);
    check("hold_dot_model", 64'(dot1), 64'(ed));
    check("hold_done", 64'(done1), 64'd0);

    // start held high through RUN: ignored, single done, then released in DONE.
    model(T1_A, T1_B, 1'b0, ep, ed);
    @(negedge clk);
    A = T1_A; B = T1_B; sgn = 1'b0; start1 = 1'b1;
    @(negedge clk);
    A = $urandom; B = $urandom;
    wait_done(1'b0, cyc);
    start1 = 1'b0;
    check("hs_lat", 64'(cyc), 64'd8);
    check("hs_prod", prod1, ep);
    @(negedge clk);
    check("hs_after", 64'({busy1, done1}), 64'd0);

    // Back-to-back: start in DONE starts the next job with no IDLE cycle.
    @(negedge clk);
    A = T1_A; B = T1_B; sgn = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1'b0, cyc);
    check("b2b_lat1", 64'(cyc), 64'd8);
    model(32'h89AB_CDEF, 32'hF0E1_D2C3, 1'b1, ep, ed);
    A = 32'h89AB_CDEF; B = 32'hF0E1_D2C3; sgn = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("b2b_busy", 64'({busy1, done1}), 64'b10);
    wait_done(1'b0, cyc);
    check("b2b_lat2", 64'(cyc), 64'd8);
    check("b2b_prod", prod1, ep);
    check("b2b_dot", 64'(dot1), 64'(ed));

    // Reset mid-job: abort asynchronously, no done.
    @(negedge clk);
    A = T1_A; B = T1_B; sgn = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rmid_ctl", 64'({busy1, done1}), 64'd0);
    check("rmid_out", prod1 | 64'(dot1), 64'd0);
    @(negedge clk);
    check("rmid_hold", 64'({busy1, done1}), 64'd0);
    reset_n = 1'b1;
    run_job(1'b0, T1_A, T1_B, 1'b0, "rpost");
    check("rpost_dot_const", 64'(dot1), 64'd56);

    // Randomized jobs on both configurations.
    for (int i = 0; i < 15; i++) begin
      run_job(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), "rnd1");
      run_job(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), "rnd2");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
